hazard_unit_mc: RTL and testbench



---
 rtl/hazard_unit_mc.sv | 108 ++++++++++
 tb/tb_hazard_unit_mc.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_unit_mc.sv
// Hazard unit for the 5-stage MIPS pipeline: forwarding, flushes,
// load-use interlock, mult/div HI/LO busy tracker and stall counter.
module hazard_unit_mc #(
   parameter int REG_AW     = 5,
   parameter int MD_LATENCY = 4,
   parameter int SCNT_W     = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [REG_AW-1:0] rs_iss_hz_i,
   input  logic [REG_AW-1:0] rt_iss_hz_i,
   input  logic [REG_AW-1:0] rs_ex_hz_i,
   input  logic [REG_AW-1:0] rt_ex_hz_i,
   input  logic [REG_AW-1:0] rd_ex_hz_i,
   input  logic              mem_rd_ex_hz_i,
   input  logic [REG_AW-1:0] rd_mem_hz_i,
   input  logic              reg_wr_mem_hz_i,
   input  logic              mem_rd_mem_hz_i,
   input  logic [REG_AW-1:0] rd_wb_hz_i,
   input  logic              reg_wr_wb_hz_i,
   input  logic              branch_taken_ex_hz_i,
   input  logic              jump_iss_hz_i,
   input  logic              md_start_ex_hz_i,
   input  logic              md_use_iss_hz_i,
   output logic              stall_fetch_hz_o,
   output logic              stall_iss_hz_o,
   output logic              flush_ex_hz_o,
   output logic              flush_iss_hz_o,
   output logic [1:0]        fwd_p1_hz_o,
   output logic [1:0]        fwd_p2_hz_o,
   output logic              md_busy_hz_o,
   output logic [SCNT_W-1:0] stall_cnt_hz_o
);

   localparam logic [3:0] MD_INIT = 4'(MD_LATENCY);
   localparam logic [SCNT_W-1:0] SCNT_MAX = {SCNT_W{1'b1}};

   logic [3:0] md_cnt;
   logic [3:0] md_cnt_nxt;
   logic       mem_ok;
   logic       wb_ok;
   logic       ex_ld_ok;
   logic       mem_ld_ok;
   logic       lu;
   logic       md;
   logic       stall;

   // A load in MEM has no result yet, so it is never a forward source
   always_comb begin
      mem_ok = reg_wr_mem_hz_i && (rd_mem_hz_i != '0) && !mem_rd_mem_hz_i;
      wb_ok  = reg_wr_wb_hz_i && (rd_wb_hz_i != '0);
      fwd_p1_hz_o = 2'b00;
      fwd_p2_hz_o = 2'b00;
      if (mem_ok && rd_mem_hz_i == rs_ex_hz_i)
         fwd_p1_hz_o = 2'b10;
      else if (wb_ok && rd_wb_hz_i == rs_ex_hz_i)
         fwd_p1_hz_o = 2'b01;
      if (mem_ok && rd_mem_hz_i == rt_ex_hz_i)
         fwd_p2_hz_o = 2'b10;
      else if (wb_ok && rd_wb_hz_i == rt_ex_hz_i)
         fwd_p2_hz_o = 2'b01;
   end

   always_comb begin
      ex_ld_ok  = mem_rd_ex_hz_i && (rd_ex_hz_i != '0);
      mem_ld_ok = mem_rd_mem_hz_i && reg_wr_mem_hz_i
                  && (rd_mem_hz_i != '0);
      lu = (ex_ld_ok && (rd_ex_hz_i == rs_iss_hz_i
                         || rd_ex_hz_i == rt_iss_hz_i))
        || (mem_ld_ok && (rd_mem_hz_i == rs_iss_hz_i
                          || rd_mem_hz_i == rt_iss_hz_i));
   end

   // md_cnt is the tracker state: zero is IDLE, nonzero is BUSY
   always_ff @(posedge clk) begin
      if (rst)
         md_cnt <= '0;
      else
         md_cnt <= md_cnt_nxt;
   end

   always_comb begin
      md_cnt_nxt = md_cnt;
      if (md_start_ex_hz_i)
         md_cnt_nxt = MD_INIT;
      else if (md_cnt != '0)
         md_cnt_nxt = md_cnt - 4'd1;
   end

   always_comb begin
      md_busy_hz_o     = (md_cnt != '0);
      md               = md_use_iss_hz_i
                         && (md_busy_hz_o || md_start_ex_hz_i);
      stall            = (lu || md) && !branch_taken_ex_hz_i;
      stall_fetch_hz_o = stall;
      stall_iss_hz_o   = stall;
      flush_ex_hz_o    = branch_taken_ex_hz_i || jump_iss_hz_i || stall;
      flush_iss_hz_o   = branch_taken_ex_hz_i;
   end

   always_ff @(posedge clk) begin
      if (rst)
         stall_cnt_hz_o <= '0;
      else if (stall && stall_cnt_hz_o != SCNT_MAX)
         stall_cnt_hz_o <= stall_cnt_hz_o + SCNT_W'(1);
   end

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Directed testbench for hazard_unit_mc; a second instance with
// SCNT_W=4 exercises stall-counter saturation.
module tb_hazard_unit_mc;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] rs_iss, rt_iss, rs_ex, rt_ex, rd_ex, rd_mem, rd_wb;
   logic       mem_rd_ex, reg_wr_mem, mem_rd_mem, reg_wr_wb;
   logic       br, jmp, md_start, md_use;
   logic       stall_f, stall_i, fl_ex, fl_iss, busy;
   logic [1:0] fwd1, fwd2;
   logic [15:0] scnt;
   logic       s_stall_f, s_stall_i, s_fl_ex, s_fl_iss, s_busy;
   logic [1:0] s_fwd1, s_fwd2;
   logic [3:0] s_scnt;

   int tests_run = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   hazard_unit_mc #(.REG_AW(5), .MD_LATENCY(4), .SCNT_W(16)) dut (
      .clk(clk), .rst(rst),
      .rs_iss_hz_i(rs_iss), .rt_iss_hz_i(rt_iss),
      .rs_ex_hz_i(rs_ex), .rt_ex_hz_i(rt_ex), .rd_ex_hz_i(rd_ex),
      .mem_rd_ex_hz_i(mem_rd_ex), .rd_mem_hz_i(rd_mem),
      .reg_wr_mem_hz_i(reg_wr_mem), .mem_rd_mem_hz_i(mem_rd_mem),
      .rd_wb_hz_i(rd_wb), .reg_wr_wb_hz_i(reg_wr_wb),
      .branch_taken_ex_hz_i(br), .jump_iss_hz_i(jmp),
      .md_start_ex_hz_i(md_start), .md_use_iss_hz_i(md_use),
      .stall_fetch_hz_o(stall_f), .stall_iss_hz_o(stall_i),
      .flush_ex_hz_o(fl_ex), .flush_iss_hz_o(fl_iss),
      .fwd_p1_hz_o(fwd1), .fwd_p2_hz_o(fwd2),
      .md_busy_hz_o(busy), .stall_cnt_hz_o(scnt)
   );

   hazard_unit_mc #(.REG_AW(5), .MD_LATENCY(4), .SCNT_W(4)) u_sat (
      .clk(clk), .rst(rst),
      .rs_iss_hz_i(rs_iss), .rt_iss_hz_i(rt_iss),
      .rs_ex_hz_i(rs_ex), .rt_ex_hz_i(rt_ex), .rd_ex_hz_i(rd_ex),
      .mem_rd_ex_hz_i(mem_rd_ex), .rd_mem_hz_i(rd_mem),
      .reg_wr_mem_hz_i(reg_wr_mem), .mem_rd_mem_hz_i(mem_rd_mem),
      .rd_wb_hz_i(rd_wb), .reg_wr_wb_hz_i(reg_wr_wb),
      .branch_taken_ex_hz_i(br), .jump_iss_hz_i(jmp),
      .md_start_ex_hz_i(md_start), .md_use_iss_hz_i(md_use),
      .stall_fetch_hz_o(s_stall_f), .stall_iss_hz_o(s_stall_i),
      .flush_ex_hz_o(s_fl_ex), .flush_iss_hz_o(s_fl_iss),
      .fwd_p1_hz_o(s_fwd1), .fwd_p2_hz_o(s_fwd2),
      .md_busy_hz_o(s_busy), .stall_cnt_hz_o(s_scnt)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      rs_iss = 0; rt_iss = 0; rs_ex = 0; rt_ex = 0;
      rd_ex = 0; rd_mem = 0; rd_wb = 0;
      mem_rd_ex = 0; reg_wr_mem = 0; mem_rd_mem = 0; reg_wr_wb = 0;
      br = 0; jmp = 0; md_start = 0; md_use = 0;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst = 1;
      tick();
      rst = 0;
   endtask

   task automatic test_reset();
      rst = 1;
      clear_inputs();
      md_start = 1;
      tick();
      tick();
      md_start = 0;
      tick();
      rst = 0;
      #1;
      tests_run++;
      if (busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_busy got %0b expected 0", busy);
      end
      tests_run++;
      if (scnt !== 16'd0) begin
         tests_failed++;
         $display("FAIL reset_scnt got %0d expected 0", scnt);
      end
      tests_run++;
      if ({stall_f, stall_i, fl_ex, fl_iss} !== 4'b0000) begin
         tests_failed++;
         $display("FAIL reset_ctl got %b expected 0000",
                  {stall_f, stall_i, fl_ex, fl_iss});
      end
   endtask

   task automatic test_forwarding();
      do_reset();
      rd_mem = 5; rd_wb = 5; rs_ex = 5;
      reg_wr_mem = 1; reg_wr_wb = 1;
      #1;
      tests_run++;
      if (fwd1 !== 2'b10) begin
         tests_failed++;
         $display("FAIL fwd_mem_prio got %b expected 10", fwd1);
      end
      reg_wr_mem = 0;
      #1;
      tests_run++;
      if (fwd1 !== 2'b01) begin
         tests_failed++;
         $display("FAIL fwd_wb got %b expected 01", fwd1);
      end
      rd_wb = 0; rs_ex = 0;
      #1;
      tests_run++;
      if (fwd1 !== 2'b00) begin
         tests_failed++;
         $display("FAIL fwd_r0 got %b expected 00", fwd1);
      end
      // load in MEM is skipped, WB supplies the older value
      rt_ex = 9; rd_mem = 9; reg_wr_mem = 1; mem_rd_mem = 1;
      rd_wb = 9; reg_wr_wb = 1;
      #1;
      tests_run++;
      if (fwd2 !== 2'b01) begin
         tests_failed++;
         $display("FAIL fwd_p2_load got %b expected 01", fwd2);
      end
      mem_rd_mem = 0; rd_wb = 3;
      #1;
      tests_run++;
      if (fwd2 !== 2'b10 || fwd1 !== 2'b00) begin
         tests_failed++;
         $display("FAIL fwd_p2_mem got %b/%b expected 10/00",
                  fwd2, fwd1);
      end
   endtask

   task automatic test_load_use();
      do_reset();
      mem_rd_ex = 1; rd_ex = 8; rs_iss = 8;
      #1;
      tests_run++;
      if (stall_f !== 1 || stall_i !== 1 || fl_ex !== 1) begin
         tests_failed++;
         $display("FAIL lu_c1 got %b%b%b expected 111",
                  stall_f, stall_i, fl_ex);
      end
      tick();
      mem_rd_ex = 0; rd_ex = 0;
      rd_mem = 8; reg_wr_mem = 1; mem_rd_mem = 1;
      #1;
      tests_run++;
      if (stall_i !== 1) begin
         tests_failed++;
         $display("FAIL lu_c2 got %b expected 1", stall_i);
      end
      tick();
      rd_mem = 0; reg_wr_mem = 0; mem_rd_mem = 0; rs_iss = 0;
      rd_wb = 8; reg_wr_wb = 1; rs_ex = 8;
      #1;
      tests_run++;
      if (stall_i !== 0 || fwd1 !== 2'b01) begin
         tests_failed++;
         $display("FAIL lu_c3 got stall %b fwd %b expected 0 01",
                  stall_i, fwd1);
      end
      tests_run++;
      if (scnt !== 16'd2) begin
         tests_failed++;
         $display("FAIL lu_cnt got %0d expected 2", scnt);
      end
   endtask

   task automatic test_md();
      do_reset();
      md_start = 1; md_use = 1;
      #1;
      tests_run++;
      if (stall_i !== 1 || busy !== 0) begin
         tests_failed++;
         $display("FAIL md_T got stall %b busy %b expected 1 0",
                  stall_i, busy);
      end
      tick();
      md_start = 0;
      for (int i = 1; i <= 4; i++) begin
         #1;
         tests_run++;
         if (stall_i !== 1 || busy !== 1) begin
            tests_failed++;
            $display("FAIL md_T+%0d got stall %b busy %b expected 1 1",
                     i, stall_i, busy);
         end
         tick();
      end
      tests_run++;
      if (stall_i !== 0 || busy !== 0) begin
         tests_failed++;
         $display("FAIL md_release got stall %b busy %b expected 0 0",
                  stall_i, busy);
      end
      tests_run++;
      if (scnt !== 16'd5) begin
         tests_failed++;
         $display("FAIL md_cnt got %0d expected 5", scnt);
      end
      // restart while busy reloads the full latency
      md_use = 0; md_start = 1;
      tick();
      md_start = 0;
      tick();
      tick();
      md_start = 1;
      tick();
      md_start = 0;
      tick();
      tick();
      tick();
      tests_run++;
      if (busy !== 1) begin
         tests_failed++;
         $display("FAIL md_restart got busy %b expected 1", busy);
      end
      tick();
      tests_run++;
      if (busy !== 0) begin
         tests_failed++;
         $display("FAIL md_restart_end got busy %b expected 0", busy);
      end
   endtask

   task automatic test_branch();
      do_reset();
      mem_rd_ex = 1; rd_ex = 4; rt_iss = 4; br = 1;
      #1;
      tests_run++;
      if ({stall_f, stall_i, fl_iss, fl_ex} !== 4'b0011) begin
         tests_failed++;
         $display("FAIL br_override got %b expected 0011",
                  {stall_f, stall_i, fl_iss, fl_ex});
      end
      tick();
      tests_run++;
      if (scnt !== 16'd0) begin
         tests_failed++;
         $display("FAIL br_cnt got %0d expected 0", scnt);
      end
      // simultaneous lu and md counts as one stall cycle
      br = 0; md_start = 1; md_use = 1;
      tick();
      clear_inputs();
      tests_run++;
      if (scnt !== 16'd1) begin
         tests_failed++;
         $display("FAIL lu_md_cnt got %0d expected 1", scnt);
      end
   endtask

   task automatic test_jump();
      do_reset();
      jmp = 1;
      #1;
      tests_run++;
      if ({stall_i, fl_ex, fl_iss} !== 3'b010) begin
         tests_failed++;
         $display("FAIL jump got %b expected 010",
                  {stall_i, fl_ex, fl_iss});
      end
      mem_rd_ex = 1; rd_ex = 7; rs_iss = 7;
      #1;
      tests_run++;
      if ({stall_i, fl_ex, fl_iss} !== 3'b110) begin
         tests_failed++;
         $display("FAIL jump_stall got %b expected 110",
                  {stall_i, fl_ex, fl_iss});
      end
      rd_ex = 0; rs_iss = 0;
      #1;
      tests_run++;
      if (stall_i !== 0) begin
         tests_failed++;
         $display("FAIL lu_r0 got %b expected 0", stall_i);
      end
   endtask

   task automatic test_reset_mid_busy();
      do_reset();
      md_start = 1; md_use = 1;
      tick();
      md_start = 0;
      tick();
      rst = 1;
      #1;
      tests_run++;
      if (stall_i !== 1) begin
         tests_failed++;
         $display("FAIL rst_comb got %b expected 1", stall_i);
      end
      tick();
      rst = 0;
      #1;
      tests_run++;
      if (busy !== 0 || scnt !== 16'd0) begin
         tests_failed++;
         $display("FAIL rst_mid got busy %b cnt %0d expected 0 0",
                  busy, scnt);
      end
      tests_run++;
      if (stall_i !== 0) begin
         tests_failed++;
         $display("FAIL rst_no_stall got %b expected 0", stall_i);
      end
      tick();
      md_use = 0;
   endtask

   task automatic test_saturation();
      do_reset();
      mem_rd_ex = 1; rd_ex = 12; rs_iss = 12;
      for (int i = 1; i <= 20; i++) begin
         tick();
         if (i == 14 || i == 15 || i == 20) begin
            tests_run++;
            if (s_scnt !== ((i >= 15) ? 4'd15 : 4'(i))) begin
               tests_failed++;
               $display("FAIL sat_cyc%0d got %0d expected %0d",
                        i, s_scnt, (i >= 15) ? 15 : i);
            end
         end
      end
      tests_run++;
      if (scnt !== 16'd20) begin
         tests_failed++;
         $display("FAIL wide_cnt got %0d expected 20", scnt);
      end
      clear_inputs();
   endtask

   initial begin
      clear_inputs();
      rst = 1;
      test_reset();
      test_forwarding();
      test_load_use();
      test_md();
      test_branch();
      test_jump();
      test_reset_mid_busy();
      test_saturation();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
